// File: rtl/cby_chany_pipe.sv
// Y-channel connection block with a per-track configurable pipeline depth (0..MAX_STAGES).
// Latency fields are loaded through a serial configuration chain; depth 0 is a plain wire.
module cby_chany_pipe #(
    parameter int unsigned NUM_TRACKS = 9,
    parameter int unsigned MAX_STAGES = 3,
    localparam int unsigned SEL_W     = $clog2(MAX_STAGES + 1),
    localparam int unsigned CFG_LEN   = 2 * NUM_TRACKS * SEL_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  config_enable,
    input  logic                  ccff_head,
    output logic                  ccff_tail,
    input  logic [NUM_TRACKS-1:0] chany_bottom_in,
    input  logic [NUM_TRACKS-1:0] chany_top_in,
    output logic [NUM_TRACKS-1:0] chany_top_out,
    output logic [NUM_TRACKS-1:0] chany_bottom_out
);

    localparam int NT2    = 2 * int'(NUM_TRACKS);
    localparam int STAGES = int'(MAX_STAGES);
    localparam int SW     = int'(SEL_W);
    localparam logic [SEL_W-1:0] MaxLat = SEL_W'(MAX_STAGES);

    logic [CFG_LEN-1:0] r_cfg;
    logic [NT2-1:0]     r_stage [STAGES];
    logic [NT2-1:0]     w_in;
    logic [NT2-1:0]     w_out;
    logic [SEL_W-1:0]   w_lat [NT2];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cfg <= '0;
        end else if (config_enable) begin
            r_cfg <= {r_cfg[CFG_LEN-2:0], ccff_head};
        end
    end

    assign ccff_tail = r_cfg[CFG_LEN-1];

    // Up tracks occupy indices 0..N-1 and down tracks N..2N-1, matching the cfg field order,
    // so track i's field always sits at r_cfg[i*SEL_W +: SEL_W].
    assign w_in = {chany_top_in, chany_bottom_in};

    always_ff @(posedge clk) begin
        if (reset || config_enable) begin
            for (int j = 0; j < STAGES; j++) begin
                r_stage[j] <= '0;
            end
        end else begin
            r_stage[0] <= w_in;
            for (int j = 1; j < STAGES; j++) begin
                r_stage[j] <= r_stage[j-1];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NT2; i++) begin
            w_lat[i] = (r_cfg[i*SW +: SEL_W] > MaxLat) ? MaxLat : r_cfg[i*SW +: SEL_W];
        end
    end

    always_comb begin
        w_out = '0;
        if (!config_enable) begin
            for (int i = 0; i < NT2; i++) begin
                w_out[i] = w_in[i];
                for (int j = 0; j < STAGES; j++) begin
                    if (w_lat[i] == SEL_W'(j + 1)) begin
                        w_out[i] = r_stage[j][i];
                    end
                end
            end
        end
    end

    assign chany_top_out    = w_out[NUM_TRACKS-1:0];
    assign chany_bottom_out = w_out[NT2-1:NUM_TRACKS];

endmodule

// File: tb/tb_cby_chany_pipe.sv
// Directed bench for cby_chany_pipe: a default build plus a MAX_STAGES=2 build sharing
// clock, reset and the configuration stream.
module tb_cby_chany_pipe;

    logic       clk;
    logic       reset;
    logic       config_enable;
    logic       ccff_head;
    logic       tail;
    logic       tail2;
    logic [8:0] bot_in;
    logic [8:0] top_in;
    logic [8:0] top_out;
    logic [8:0] bot_out;
    logic [8:0] top_out2;
    logic [8:0] bot_out2;

    int n_chk  = 0;
    int n_fail = 0;

    cby_chany_pipe u_dut (
        .clk              (clk),
        .reset            (reset),
        .config_enable    (config_enable),
        .ccff_head        (ccff_head),
        .ccff_tail        (tail),
        .chany_bottom_in  (bot_in),
        .chany_top_in     (top_in),
        .chany_top_out    (top_out),
        .chany_bottom_out (bot_out)
    );

    cby_chany_pipe #(
        .NUM_TRACKS (9),
        .MAX_STAGES (2)
    ) u_dut2 (
        .clk              (clk),
        .reset            (reset),
        .config_enable    (config_enable),
        .ccff_head        (ccff_head),
        .ccff_tail        (tail2),
        .chany_bottom_in  (bot_in),
        .chany_top_in     (top_in),
        .chany_top_out    (top_out2),
        .chany_bottom_out (bot_out2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [35:0] got, input logic [35:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Shifts v MSB-first so that v[k] ends up in cfg[k].
    task automatic load_cfg(input logic [35:0] v);
        config_enable = 1'b1;
        for (int i = 35; i >= 0; i--) begin
            ccff_head = v[i];
            tick();
        end
        config_enable = 1'b0;
        ccff_head     = 1'b0;
    endtask

    logic [35:0] pat;
    logic [8:0]  sb [20];
    logic [8:0]  st [20];
    logic [8:0]  eb;
    logic [8:0]  et;
    logic        en;

    initial begin
        reset         = 1'b1;
        config_enable = 1'b0;
        ccff_head     = 1'b0;
        bot_in        = '0;
        top_in        = '0;
        tick();

        // Reset bypass
        reset  = 1'b0;
        bot_in = 9'h1A5;
        top_in = 9'h05A;
        #1;
        check_val("rst_top_out", 36'(top_out), 36'h1A5);
        check_val("rst_bot_out", 36'(bot_out), 36'h05A);
        check_val("rst_tail", 36'(tail), 36'h0);

        // Chain integrity
        pat           = 36'hA5A5A5A5A;
        config_enable = 1'b1;
        for (int i = 35; i >= 0; i--) begin
            ccff_head = pat[i];
            tick();
        end
        check_val("cfg_forces_out0", 36'(top_out), 36'h0);
        check_val("chain_bit35", 36'(tail), 36'(pat[35]));
        for (int j = 1; j < 36; j++) begin
            ccff_head = 1'b0;
            tick();
            check_val($sformatf("chain_bit%0d", 35 - j), 36'(tail), 36'(pat[35 - j]));
        end
        ccff_head = 1'b0;
        tick();
        config_enable = 1'b0;
        check_val("chain_drained", 36'(tail), 36'h0);

        // Per-track latency: up t0 L=1, t1 L=2, t2 L=3
        load_cfg(36'h39);
        top_in = 9'h0AA;
        bot_in = 9'h027;
        #1;
        check_val("lat_c0_top", 36'(top_out), 36'h020);
        check_val("lat_c0_bot", 36'(bot_out), 36'h0AA);
        tick();
        bot_in = 9'h000;
        #1;
        check_val("lat_c1_top", 36'(top_out), 36'h001);
        tick();
        check_val("lat_c2_top", 36'(top_out), 36'h002);
        tick();
        check_val("lat_c3_top", 36'(top_out), 36'h004);
        check_val("lat_c3_bot", 36'(bot_out), 36'h0AA);
        tick();
        check_val("lat_c4_top", 36'(top_out), 36'h000);

        // Flush on config with L=3 everywhere; head held at 1 keeps the fields intact
        load_cfg(36'hFFFFFFFFF);
        for (int c = 0; c < 20; c++) begin
            en            = (c >= 6 && c <= 10);
            config_enable = en;
            ccff_head     = 1'b1;
            bot_in        = 9'h100 | 9'(c * 29);
            top_in        = ~bot_in;
            #1;
            sb[c] = en ? 9'h0 : bot_in;
            st[c] = en ? 9'h0 : top_in;
            eb    = 9'h0;
            et    = 9'h0;
            if (!en && c >= 3) begin
                eb = sb[c - 3];
                et = st[c - 3];
            end
            check_val($sformatf("flush_top_c%0d", c), 36'(top_out), 36'(eb));
            check_val($sformatf("flush_bot_c%0d", c), 36'(bot_out), 36'(et));
            tick();
        end
        config_enable = 1'b0;
        ccff_head     = 1'b0;

        // Clamp: down track 4 field 3 (cfg bits 27:26)
        load_cfg(36'h00C000000);
        bot_in = 9'h000;
        top_in = 9'h010;
        #1;
        check_val("clamp_c0", 36'(bot_out2), 36'h000);
        tick();
        top_in = 9'h000;
        #1;
        check_val("clamp_c1", 36'(bot_out2), 36'h000);
        tick();
        check_val("clamp_c2", 36'(bot_out2), 36'h010);
        check_val("noclamp_c2", 36'(bot_out), 36'h000);
        tick();
        check_val("clamp_c3", 36'(bot_out2), 36'h000);
        check_val("noclamp_c3", 36'(bot_out), 36'h010);

        // Reset mid-shift, with config_enable still high
        config_enable = 1'b1;
        ccff_head     = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
        end
        reset = 1'b1;
        tick();
        reset         = 1'b0;
        config_enable = 1'b0;
        ccff_head     = 1'b0;
        bot_in        = 9'h1FF;
        top_in        = 9'h0F0;
        #1;
        check_val("abort_top_bypass", 36'(top_out), 36'h1FF);
        check_val("abort_bot_bypass", 36'(bot_out), 36'h0F0);
        check_val("abort_tail", 36'(tail), 36'h0);
        load_cfg(36'h39);
        bot_in = 9'h007;
        top_in = 9'h000;
        #1;
        check_val("fresh_c0", 36'(top_out), 36'h000);
        tick();
        bot_in = 9'h000;
        #1;
        check_val("fresh_c1", 36'(top_out), 36'h001);
        tick();
        check_val("fresh_c2", 36'(top_out), 36'h002);
        tick();
        check_val("fresh_c3", 36'(top_out), 36'h004);
        tick();
        check_val("fresh_c4", 36'(top_out), 36'h000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
